ifid_skid_stage: RTL and testbench

//  Parametrised IF/ID pipeline stage: a DEPTH-entry FIFO (skid buffer) between fetch and decode.

---
 rtl/ifid_skid_stage.sv | 123 ++++++++++++
 tb/tb_ifid_skid_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifid_skid_stage.sv
// rtl/ifid_skid_stage.sv - IF/ID skid-buffer FIFO stage with flush and head field decode
module ifid_skid_stage #(
  parameter int PC_W  = 9,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   input_pc,
  input  logic [31:0]       instruction_in,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [31:0]       instruction_out,
  output logic [PC_W-1:0]   PC,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm16,
  output logic [25:0]       address_26,
  output logic [CNT_W-1:0]  occupancy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      instr_mem_d [DEPTH];
  logic [PC_W-1:0]  pc_mem_q    [DEPTH];
  logic [PC_W-1:0]  pc_mem_d    [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             push, pop;
  logic [31:0]      head_instr;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Handshake status comes only from registered occupancy; flush suppresses both transfers.
  always_comb begin
    in_ready  = (occ_q < DEPTH_C);
    out_valid = (occ_q != '0);
    push      = in_valid & in_ready & ~flush;
    pop       = out_valid & out_ready & ~flush;
  end

  // Next-state: flush empties the stage; otherwise write at tail, advance head on pop.
  always_comb begin
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    head_d      = head_q;
    tail_d      = tail_q;
    occ_d       = occ_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (push) begin
        instr_mem_d[tail_q] = instruction_in;
        pc_mem_d[tail_q]    = input_pc;
        tail_d              = next_ptr(tail_q);
      end
      if (pop) begin
        head_d = next_ptr(head_q);
      end
      occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State registers; reset also clears the storage so nothing stale can resurface.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      instr_mem_q <= instr_mem_d;
      pc_mem_q    <= pc_mem_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      occ_q       <= occ_d;
    end
  end

  // Head decode: an empty stage presents an all-zero bubble, which decodes as an R-format NOP.
  always_comb begin
    head_instr      = out_valid ? instr_mem_q[head_q] : '0;
    PC              = out_valid ? pc_mem_q[head_q] : '0;
    instruction_out = head_instr;
    opcode          = head_instr[31:26];
    rs              = '0;
    rt              = '0;
    rd              = '0;
    imm16           = '0;
    address_26      = '0;
    if (head_instr[31:26] == 6'b000000) begin
      rs = head_instr[25:21];
      rt = head_instr[20:16];
      rd = head_instr[15:11];
    end else if (head_instr[31:27] == 5'b00001) begin
      address_26 = head_instr[25:0];
    end else begin
      rs    = head_instr[25:21];
      rt    = head_instr[20:16];
      imm16 = head_instr[15:0];
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_ifid_skid_stage.sv
// tb/tb_ifid_skid_stage.sv - bench for ifid_skid_stage at DEPTH=2 and DEPTH=1
module tb_ifid_skid_stage;

  typedef struct packed {
    logic [31:0] valid, ready, occ, instr, pc, op, rs, rt, rd, imm, addr;
  } obs_t;

  typedef struct {
    logic        iv;
    logic [31:0] ins;
    logic [8:0]  pc;
    logic        fl;
    logic        ordy;
    obs_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic [8:0] input_pc = '0;
  logic [31:0] instruction_in = '0;
  logic flush = 1'b0;
  logic out_ready = 1'b0;

  logic d2_in_ready, d2_out_valid, d1_in_ready, d1_out_valid;
  logic [31:0] d2_instr, d1_instr;
  logic [8:0] d2_pc, d1_pc;
  logic [5:0] d2_op, d1_op;
  logic [4:0] d2_rs, d2_rt, d2_rd, d1_rs, d1_rt, d1_rd;
  logic [15:0] d2_imm, d1_imm;
  logic [25:0] d2_addr, d1_addr;
  logic [1:0] d2_occ;
  logic [0:0] d1_occ;

  int checks = 0;
  int failures = 0;
  int pops2 = 0;
  int pops1 = 0;
  logic [40:0] q2[$];
  logic [40:0] q1[$];
  obs_t a2, a1;
  vec_t vecs[9];

  always #5 clk = ~clk;

  ifid_skid_stage #(.PC_W(9), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d2_in_ready),
    .input_pc(input_pc), .instruction_in(instruction_in), .flush(flush),
    .out_ready(out_ready), .out_valid(d2_out_valid), .instruction_out(d2_instr),
    .PC(d2_pc), .opcode(d2_op), .rs(d2_rs), .rt(d2_rt), .rd(d2_rd),
    .imm16(d2_imm), .address_26(d2_addr), .occupancy(d2_occ)
  );

  ifid_skid_stage #(.PC_W(9), .DEPTH(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d1_in_ready),
    .input_pc(input_pc), .instruction_in(instruction_in), .flush(flush),
    .out_ready(out_ready), .out_valid(d1_out_valid), .instruction_out(d1_instr),
    .PC(d1_pc), .opcode(d1_op), .rs(d1_rs), .rt(d1_rt), .rd(d1_rd),
    .imm16(d1_imm), .address_26(d1_addr), .occupancy(d1_occ)
  );

  always_comb begin
    a2 = '0;
    a2.valid = 32'(d2_out_valid); a2.ready = 32'(d2_in_ready); a2.occ = 32'(d2_occ);
    a2.instr = d2_instr; a2.pc = 32'(d2_pc); a2.op = 32'(d2_op);
    a2.rs = 32'(d2_rs); a2.rt = 32'(d2_rt); a2.rd = 32'(d2_rd);
    a2.imm = 32'(d2_imm); a2.addr = 32'(d2_addr);
    a1 = '0;
    a1.valid = 32'(d1_out_valid); a1.ready = 32'(d1_in_ready); a1.occ = 32'(d1_occ);
    a1.instr = d1_instr; a1.pc = 32'(d1_pc); a1.op = 32'(d1_op);
    a1.rs = 32'(d1_rs); a1.rt = 32'(d1_rt); a1.rd = 32'(d1_rd);
    a1.imm = 32'(d1_imm); a1.addr = 32'(d1_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic obs_t mk(input int v, input int r, input int o, input logic [31:0] ins,
                              input logic [31:0] pc, input logic [31:0] op, input logic [31:0] rs_v,
                              input logic [31:0] rt_v, input logic [31:0] rd_v,
                              input logic [31:0] imm, input logic [31:0] addr);
    obs_t e;
    e.valid = 32'(v); e.ready = 32'(r); e.occ = 32'(o); e.instr = ins; e.pc = pc; e.op = op;
    e.rs = rs_v; e.rt = rt_v; e.rd = rd_v; e.imm = imm; e.addr = addr;
    return e;
  endfunction

  // Expected outputs from the queue contents, following the format rules directly.
  function automatic obs_t expect_of(input int size, input int depth, input logic [40:0] head);
    obs_t e;
    int op;
    e = '0;
    e.valid = (size > 0) ? 32'd1 : 32'd0;
    e.ready = (size < depth) ? 32'd1 : 32'd0;
    e.occ = 32'(size);
    if (size > 0) begin
      e.instr = head[31:0];
      e.pc = 32'(head[40:32]);
      op = int'(head[31:26]);
      e.op = 32'(op);
      if (op == 0) begin
        e.rs = 32'(head[25:21]); e.rt = 32'(head[20:16]); e.rd = 32'(head[15:11]);
      end else if (op == 2 || op == 3) begin
        e.addr = 32'(head[25:0]);
      end else begin
        e.rs = 32'(head[25:21]); e.rt = 32'(head[20:16]); e.imm = 32'(head[15:0]);
      end
    end
    return e;
  endfunction

  task automatic cmp(input string tag, input obs_t act, input obs_t exp);
    chk({tag, ".out_valid"}, act.valid, exp.valid);
    chk({tag, ".in_ready"}, act.ready, exp.ready);
    chk({tag, ".occupancy"}, act.occ, exp.occ);
    chk({tag, ".instruction_out"}, act.instr, exp.instr);
    chk({tag, ".PC"}, act.pc, exp.pc);
    chk({tag, ".opcode"}, act.op, exp.op);
    chk({tag, ".rs"}, act.rs, exp.rs);
    chk({tag, ".rt"}, act.rt, exp.rt);
    chk({tag, ".rd"}, act.rd, exp.rd);
    chk({tag, ".imm16"}, act.imm, exp.imm);
    chk({tag, ".address_26"}, act.addr, exp.addr);
  endtask

  task automatic check_models(input string tag);
    cmp({tag, ".d2"}, a2, expect_of(q2.size(), 2, (q2.size() > 0) ? q2[0] : 41'd0));
    cmp({tag, ".d1"}, a1, expect_of(q1.size(), 1, (q1.size() > 0) ? q1[0] : 41'd0));
  endtask

  // One clock: drive inputs after the falling edge, advance the models at the rising edge,
  // compare on the next falling edge.
  task automatic step(input string tag, input logic iv, input logic [31:0] ins,
                      input logic [8:0] pc, input logic fl, input logic ordy);
    bit push2, pop2, push1, pop1;
    in_valid = iv; instruction_in = ins; input_pc = pc; flush = fl; out_ready = ordy;
    push2 = iv && (q2.size() < 2) && !fl;
    pop2  = (q2.size() > 0) && ordy && !fl;
    push1 = iv && (q1.size() < 1) && !fl;
    pop1  = (q1.size() > 0) && ordy && !fl;
    if (d2_out_valid && ordy && !fl) pops2++;
    if (d1_out_valid && ordy && !fl) pops1++;
    @(posedge clk);
    if (fl) begin
      q2.delete(); q1.delete();
    end else begin
      if (pop2) void'(q2.pop_front());
      if (push2) q2.push_back({pc, ins});
      if (pop1) void'(q1.pop_front());
      if (push1) q1.push_back({pc, ins});
    end
    @(negedge clk);
    check_models(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op;
    vecs[0] = '{1'b1, 32'h24A50010, 9'h004, 1'b0, 1'b0, mk(1, 1, 1, 32'h24A50010, 32'h004, 32'h09, 5, 5, 0, 32'h0010, 0)};
    vecs[1] = '{1'b1, 32'h0C000040, 9'h008, 1'b0, 1'b0, mk(1, 0, 2, 32'h24A50010, 32'h004, 32'h09, 5, 5, 0, 32'h0010, 0)};
    vecs[2] = '{1'b1, 32'h00A31021, 9'h00C, 1'b0, 1'b0, mk(1, 0, 2, 32'h24A50010, 32'h004, 32'h09, 5, 5, 0, 32'h0010, 0)};
    vecs[3] = '{1'b0, 32'h00000000, 9'h000, 1'b0, 1'b1, mk(1, 1, 1, 32'h0C000040, 32'h008, 32'h03, 0, 0, 0, 0, 32'h0000040)};
    vecs[4] = '{1'b1, 32'h00A31021, 9'h00C, 1'b0, 1'b1, mk(1, 1, 1, 32'h00A31021, 32'h00C, 32'h00, 5, 3, 2, 0, 0)};
    vecs[5] = '{1'b1, 32'hDEADBEEF, 9'h010, 1'b1, 1'b0, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[6] = '{1'b0, 32'h00000000, 9'h000, 1'b0, 1'b1, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[7] = '{1'b1, 32'h00000000, 9'h014, 1'b0, 1'b0, mk(1, 1, 1, 0, 32'h014, 0, 0, 0, 0, 0, 0)};
    vecs[8] = '{1'b0, 32'h00000000, 9'h000, 1'b0, 1'b1, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};

    // Power-on reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_models("reset");
    cmp("reset_const", a2, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Asynchronous reset with two entries held.
    step("fill_a", 1'b1, 32'h11111111, 9'h020, 1'b0, 1'b0);
    step("fill_b", 1'b1, 32'h22222222, 9'h024, 1'b0, 1'b0);
    chk("mid_reset.pre_occ", a2.occ, 32'd2);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    cmp("mid_reset.async", a2, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q2.delete(); q1.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_models("mid_reset.after");

    // Directed vector table on the DEPTH=2 instance.
    for (int i = 0; i < 9; i++) begin
      step($sformatf("vec%0d", i), vecs[i].iv, vecs[i].ins, vecs[i].pc, vecs[i].fl, vecs[i].ordy);
      cmp($sformatf("vec%0d_const", i), a2, vecs[i].exp);
    end

    // Flush while full with a beat offered: that beat must never emerge.
    step("fl_a", 1'b1, 32'h8C410004, 9'h030, 1'b0, 1'b0);
    step("fl_b", 1'b1, 32'h08000123, 9'h034, 1'b0, 1'b0);
    chk("flush.pre_occ", a2.occ, 32'd2);
    step("fl_hit", 1'b1, 32'hBAD0BAD0, 9'h038, 1'b1, 1'b1);
    chk("flush.occ", a2.occ, 32'd0);
    chk("flush.out_valid", a2.valid, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step("fl_drain", 1'b0, 32'h0, 9'h0, 1'b0, 1'b1);
      chk("flush.no_ghost", a2.instr, 32'd0);
    end

    // Randomised traffic against the queue models.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: op = 6'h00;
        1: op = 6'h02;
        2: op = 6'h03;
        default: op = 6'($urandom);
      endcase
      step("rand", 1'($urandom_range(0, 3) != 0), {op, 26'($urandom)}, 9'($urandom),
           ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0));
    end

    // Sustained streaming from empty: throughput per depth.
    step("stream_flush", 1'b0, 32'h0, 9'h0, 1'b1, 1'b0);
    pops2 = 0;
    pops1 = 0;
    for (int i = 0; i < 20; i++) begin
      step("stream", 1'b1, 32'h20000000 + 32'(i), 9'(i * 4), 1'b0, 1'b1);
    end
    chk("stream.d2_pops", 32'(pops2), 32'd19);
    chk("stream.d1_pops", 32'(pops1), 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
